// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: core load/store port, loader port and the shared
// four-lane BRAM port. The arbiter takes the slave view, its environment the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  C_REQ;
  logic                  C_WE;
  logic [ADDR_WIDTH-1:0] C_ADDR;
  logic [1:0]            C_SIZE;
  logic                  C_UNSIGNED;
  logic [31:0]           C_WDATA;
  logic                  C_GNT;
  logic                  C_RVALID;
  logic [31:0]           C_RDATA;
  logic                  C_ERR;

  logic                  L_REQ;
  logic                  L_WE;
  logic [ADDR_WIDTH-1:0] L_ADDR;
  logic [31:0]           L_WDATA;
  logic                  L_GNT;
  logic                  L_RVALID;
  logic [31:0]           L_RDATA;

  logic [ADDR_WIDTH-3:0] M_ADDR;
  logic [3:0]            M_WE;
  logic                  M_RE;
  logic [31:0]           M_DIN;
  logic [31:0]           M_DOUT;

  modport slave (
    input  C_REQ, C_WE, C_ADDR, C_SIZE, C_UNSIGNED, C_WDATA,
    output C_GNT, C_RVALID, C_RDATA, C_ERR,
    input  L_REQ, L_WE, L_ADDR, L_WDATA,
    output L_GNT, L_RVALID, L_RDATA,
    output M_ADDR, M_WE, M_RE, M_DIN,
    input  M_DOUT
  );

  modport master (
    output C_REQ, C_WE, C_ADDR, C_SIZE, C_UNSIGNED, C_WDATA,
    input  C_GNT, C_RVALID, C_RDATA, C_ERR,
    output L_REQ, L_WE, L_ADDR, L_WDATA,
    input  L_GNT, L_RVALID, L_RDATA,
    input  M_ADDR, M_WE, M_RE, M_DIN,
    output M_DOUT
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: round-robin between core and loader onto four byte-lane BRAMs,
// with store lane enables and load realignment. DMEM_MISALIGN_TRAP_EN enables the misalignment trap.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 8
) (
  input logic           CLK,
  input logic           RST,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    OWN_CORE   = 1'b0,
    OWN_LOADER = 1'b1
  } owner_e;

  owner_e     last_r;
  owner_e     tag_owner_r;
  logic       tag_valid_r;
  logic       tag_err_r;
  logic       tag_uns_r;
  logic [1:0] tag_off_r;
  logic [1:0] tag_size_r;

  logic       c_win_s;
  logic       l_win_s;
  logic       c_trap_s;
  logic [1:0] c_off_s;
  logic       unused_ok_s;

  function automatic logic [3:0] store_lanes(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    store_lanes = 4'b0001 << off;
      2'd1:    store_lanes = off[1] ? 4'b1100 : 4'b0011;
      default: store_lanes = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'd0:    store_data = {4{wdata[7:0]}};
      2'd1:    store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] off,
                                               input logic uns, input logic [31:0] dout);
    logic [7:0]  b;
    logic [15:0] h;
    b = dout[{off, 3'b000} +: 8];
    h = off[1] ? dout[31:16] : dout[15:0];
    case (size)
      2'd0:    load_extract = {{24{~uns & b[7]}}, b};
      2'd1:    load_extract = {{16{~uns & h[15]}}, h};
      default: load_extract = dout;
    endcase
  endfunction

  // Loader byte-offset bits are architecturally ignored.
  assign unused_ok_s = ^bus.L_ADDR[1:0];

  // Arbitration: a lone requester wins; on contention the side not granted last wins.
  always_comb begin
    c_win_s = 1'b0;
    l_win_s = 1'b0;
    if (RST) begin
      c_win_s = 1'b0;
      l_win_s = 1'b0;
    end else if (bus.C_REQ && bus.L_REQ) begin
      c_win_s = (last_r == OWN_LOADER);
      l_win_s = (last_r == OWN_CORE);
    end else begin
      c_win_s = bus.C_REQ;
      l_win_s = bus.L_REQ;
    end
  end

  // Effective core byte offset with misaligned low bits forced to zero.
  always_comb begin
    c_off_s = 2'b00;
    case (bus.C_SIZE)
      2'd0:    c_off_s = bus.C_ADDR[1:0];
      2'd1:    c_off_s = {bus.C_ADDR[1], 1'b0};
      default: c_off_s = 2'b00;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic c_misalign_s;

  // Misaligned core accesses are granted but never reach the BRAMs.
  always_comb begin
    c_misalign_s = 1'b0;
    case (bus.C_SIZE)
      2'd0:    c_misalign_s = 1'b0;
      2'd1:    c_misalign_s = bus.C_ADDR[0];
      default: c_misalign_s = |bus.C_ADDR[1:0];
    endcase
  end

  assign c_trap_s = c_win_s & c_misalign_s;
`else
  assign c_trap_s = 1'b0;
`endif

  assign bus.C_GNT = c_win_s;
  assign bus.L_GNT = l_win_s;

  // Shared BRAM port driven for the winner; idle value is all zero.
  always_comb begin
    bus.M_ADDR = '0;
    bus.M_WE   = 4'b0000;
    bus.M_RE   = 1'b0;
    bus.M_DIN  = 32'h0000_0000;
    if (c_win_s && !c_trap_s) begin
      bus.M_ADDR = bus.C_ADDR[ADDR_WIDTH-1:2];
      if (bus.C_WE) begin
        bus.M_WE  = store_lanes(bus.C_SIZE, c_off_s);
        bus.M_DIN = store_data(bus.C_SIZE, bus.C_WDATA);
      end else begin
        bus.M_RE = 1'b1;
      end
    end else if (l_win_s) begin
      bus.M_ADDR = bus.L_ADDR[ADDR_WIDTH-1:2];
      if (bus.L_WE) begin
        bus.M_WE  = 4'b1111;
        bus.M_DIN = bus.L_WDATA;
      end else begin
        bus.M_RE = 1'b1;
      end
    end else begin
      bus.M_RE = 1'b0;
    end
  end

  // Round-robin pointer and response tag captured at grant.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_r      <= OWN_LOADER;
      tag_valid_r <= 1'b0;
      tag_err_r   <= 1'b0;
      tag_owner_r <= OWN_CORE;
      tag_off_r   <= 2'b00;
      tag_size_r  <= 2'b00;
      tag_uns_r   <= 1'b0;
    end else begin
      if (c_win_s) begin
        last_r <= OWN_CORE;
      end else if (l_win_s) begin
        last_r <= OWN_LOADER;
      end else begin
        last_r <= last_r;
      end
      tag_valid_r <= (c_win_s && !bus.C_WE) || (l_win_s && !bus.L_WE);
      tag_err_r   <= c_trap_s;
      tag_owner_r <= l_win_s ? OWN_LOADER : OWN_CORE;
      tag_off_r   <= c_off_s;
      tag_size_r  <= bus.C_SIZE;
      tag_uns_r   <= bus.C_UNSIGNED;
    end
  end

  // Response steering; RST suppresses any response already in flight.
  always_comb begin
    bus.C_RVALID = 1'b0;
    bus.C_RDATA  = 32'h0000_0000;
    bus.C_ERR    = 1'b0;
    bus.L_RVALID = 1'b0;
    bus.L_RDATA  = 32'h0000_0000;
    if (!RST) begin
      bus.C_ERR = tag_err_r;
      if (tag_valid_r && (tag_owner_r == OWN_CORE)) begin
        bus.C_RVALID = 1'b1;
        bus.C_RDATA  = tag_err_r ? 32'h0000_0000
                                 : load_extract(tag_size_r, tag_off_r, tag_uns_r, bus.M_DOUT);
      end else if (tag_valid_r && (tag_owner_r == OWN_LOADER)) begin
        bus.L_RVALID = 1'b1;
        bus.L_RDATA  = bus.M_DOUT;
      end else begin
        bus.C_RVALID = 1'b0;
      end
    end else begin
      bus.C_ERR = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: byte-array memory reference model, directed
// table, contention/reset sequences and randomized traffic.
module tb_dmem_arbiter;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic [7:0] bram [0:3][0:63];

  dmem_arbiter_if #(.ADDR_WIDTH(8)) bus ();
  dmem_arbiter #(.ADDR_WIDTH(8)) dut (.CLK(clk), .RST(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Four byte-lane BRAMs with registered read output
  always @(posedge clk) begin
    if (bus.M_RE) bus.M_DOUT <= {bram[3][bus.M_ADDR], bram[2][bus.M_ADDR],
                                 bram[1][bus.M_ADDR], bram[0][bus.M_ADDR]};
    for (int i = 0; i < 4; i++)
      if (bus.M_WE[i]) bram[i][bus.M_ADDR] <= bus.M_DIN[8*i +: 8];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0]  ref_mem [0:255];
  bit          m_last_core = 1'b0;
  bit          p_cv, p_lv, p_err;
  logic [31:0] p_cd, p_ld;

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] wdata;
    logic [3:0]  x_we;
    bit          x_re;
    logic [31:0] x_din;
    bit          x_rv;
    logic [31:0] x_rd;
    bit          x_err;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_core(input bit req, input bit we, input logic [7:0] addr,
                          input logic [1:0] size, input bit uns, input logic [31:0] wdata);
    bus.C_REQ = req; bus.C_WE = we; bus.C_ADDR = addr;
    bus.C_SIZE = size; bus.C_UNSIGNED = uns; bus.C_WDATA = wdata;
  endtask

  task automatic set_ldr(input bit req, input bit we, input logic [7:0] addr, input logic [31:0] wdata);
    bus.L_REQ = req; bus.L_WE = we; bus.L_ADDR = addr; bus.L_WDATA = wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Sample mid-cycle, compare against the model, then advance the model one cycle.
  task automatic check_cycle(output bit cg, output bit lg);
    bit          trap;
    int          nb, base, off0, la;
    logic [3:0]  we;
    logic [31:0] din, val;
    logic [5:0]  ma;
    bit          re;
    #4;
    cg = 1'b0; lg = 1'b0;
    if (!rst) begin
      if (bus.C_REQ && bus.L_REQ) begin
        cg = !m_last_core;
        lg = m_last_core;
      end else begin
        cg = bus.C_REQ;
        lg = bus.L_REQ;
      end
    end
    we = 4'b0000; re = 1'b0; din = 32'h0; ma = 6'd0; trap = 1'b0;
    nb   = (bus.C_SIZE == 2'd0) ? 1 : (bus.C_SIZE == 2'd1) ? 2 : 4;
    base = int'(bus.C_ADDR) - (int'(bus.C_ADDR) % nb);
    off0 = base % 4;
    la   = int'(bus.L_ADDR) - (int'(bus.L_ADDR) % 4);
    if (cg) begin
      trap = TRAP_EN && ((int'(bus.C_ADDR) % nb) != 0);
      if (!trap) begin
        ma = 6'(base / 4);
        if (bus.C_WE) begin
          for (int k = 0; k < 4; k++) begin
            din[8*k +: 8] = bus.C_WDATA[8*(k % nb) +: 8];
            we[k] = (k >= off0) && (k < off0 + nb);
          end
        end else begin
          re = 1'b1;
        end
      end
    end else if (lg) begin
      ma = 6'(la / 4);
      if (bus.L_WE) begin
        we = 4'b1111; din = bus.L_WDATA;
      end else begin
        re = 1'b1;
      end
    end
    chk("C_GNT", 32'(bus.C_GNT), 32'(cg));
    chk("L_GNT", 32'(bus.L_GNT), 32'(lg));
    chk("M_WE", 32'(bus.M_WE), 32'(we));
    chk("M_RE", 32'(bus.M_RE), 32'(re));
    chk("M_ADDR", 32'(bus.M_ADDR), 32'(ma));
    chk("M_DIN", bus.M_DIN, din);
    chk("C_RVALID", 32'(bus.C_RVALID), rst ? 32'd0 : 32'(p_cv));
    chk("C_RDATA", bus.C_RDATA, rst ? 32'd0 : p_cd);
    chk("C_ERR", 32'(bus.C_ERR), rst ? 32'd0 : 32'(p_err));
    chk("L_RVALID", 32'(bus.L_RVALID), rst ? 32'd0 : 32'(p_lv));
    chk("L_RDATA", bus.L_RDATA, rst ? 32'd0 : p_ld);
    p_cv = 1'b0; p_lv = 1'b0; p_err = 1'b0; p_cd = 32'h0; p_ld = 32'h0;
    if (rst) begin
      m_last_core = 1'b0;
    end else begin
      if (cg) m_last_core = 1'b1;
      else if (lg) m_last_core = 1'b0;
      if (cg) begin
        p_err = trap;
        if (!bus.C_WE) begin
          p_cv = 1'b1;
          val = 32'h0;
          for (int k = 0; k < nb; k++) val[8*k +: 8] = ref_mem[base + k];
          if (!bus.C_UNSIGNED && nb < 4 && val[8*nb-1])
            for (int k = nb; k < 4; k++) val[8*k +: 8] = 8'hFF;
          p_cd = trap ? 32'h0 : val;
        end else if (!trap) begin
          for (int k = 0; k < nb; k++) ref_mem[base + k] = bus.C_WDATA[8*k +: 8];
        end
      end
      if (lg) begin
        if (!bus.L_WE) begin
          p_lv = 1'b1;
          p_ld = {ref_mem[la+3], ref_mem[la+2], ref_mem[la+1], ref_mem[la]};
        end else begin
          for (int k = 0; k < 4; k++) ref_mem[la + k] = bus.L_WDATA[8*k +: 8];
        end
      end
    end
  endtask

  initial begin
    bit cg, lg, c_hold, l_hold;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    p_cv = 1'b0; p_lv = 1'b0; p_err = 1'b0; p_cd = 32'h0; p_ld = 32'h0;

    tbl[0]  = '{1'b1, 8'h10, 2'd2, 1'b0, 32'h11223344, 4'b1111, 1'b0, 32'h11223344, 1'b0, 32'h0, 1'b0};
    tbl[1]  = '{1'b1, 8'h11, 2'd0, 1'b0, 32'h000000AA, 4'b0010, 1'b0, 32'hAAAAAAAA, 1'b0, 32'h0, 1'b0};
    tbl[2]  = '{1'b1, 8'h12, 2'd1, 1'b0, 32'h0000BEEF, 4'b1100, 1'b0, 32'hBEEFBEEF, 1'b0, 32'h0, 1'b0};
    tbl[3]  = '{1'b0, 8'h10, 2'd2, 1'b0, 32'h0, 4'b0000, 1'b1, 32'h0, 1'b1, 32'hBEEFAA44, 1'b0};
    tbl[4]  = '{1'b0, 8'h11, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b1, 32'h0, 1'b1, 32'hFFFFFFAA, 1'b0};
    tbl[5]  = '{1'b0, 8'h11, 2'd0, 1'b1, 32'h0, 4'b0000, 1'b1, 32'h0, 1'b1, 32'h000000AA, 1'b0};
    tbl[6]  = '{1'b0, 8'h12, 2'd1, 1'b0, 32'h0, 4'b0000, 1'b1, 32'h0, 1'b1, 32'hFFFFBEEF, 1'b0};
    tbl[7]  = '{1'b0, 8'h12, 2'd1, 1'b1, 32'h0, 4'b0000, 1'b1, 32'h0, 1'b1, 32'h0000BEEF, 1'b0};
    tbl[8]  = '{1'b0, 8'h13, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b1, 32'h0, 1'b1, 32'hFFFFFFBE, 1'b0};
    tbl[9]  = '{1'b0, 8'h10, 2'd1, 1'b0, 32'h0, 4'b0000, 1'b1, 32'h0, 1'b1, 32'hFFFFAA44, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
    tbl[10] = '{1'b0, 8'h13, 2'd2, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1};
    tbl[11] = '{1'b1, 8'h11, 2'd1, 1'b0, 32'h00001234, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1};
    tbl[12] = '{1'b0, 8'h10, 2'd2, 1'b0, 32'h0, 4'b0000, 1'b1, 32'h0, 1'b1, 32'hBEEFAA44, 1'b0};
`else
    tbl[10] = '{1'b0, 8'h13, 2'd2, 1'b0, 32'h0, 4'b0000, 1'b1, 32'h0, 1'b1, 32'hBEEFAA44, 1'b0};
    tbl[11] = '{1'b1, 8'h11, 2'd1, 1'b0, 32'h00001234, 4'b0011, 1'b0, 32'h12341234, 1'b0, 32'h0, 1'b0};
    tbl[12] = '{1'b0, 8'h10, 2'd2, 1'b0, 32'h0, 4'b0000, 1'b1, 32'h0, 1'b1, 32'hBEEF1234, 1'b0};
`endif

    // Reset with both requesting: no grants, all outputs quiet
    rst = 1'b1;
    set_core(1'b1, 1'b0, 8'h00, 2'd2, 1'b0, 32'h0);
    set_ldr(1'b1, 1'b0, 8'h00, 32'h0);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      check_cycle(cg, lg);
      chk("rst_c_gnt", 32'(bus.C_GNT), 32'd0);
      chk("rst_l_gnt", 32'(bus.L_GNT), 32'd0);
      next_cycle();
    end

    // First contention after release goes to the core; loader holds and then fills memory
    rst = 1'b0;
    set_core(1'b1, 1'b1, 8'h00, 2'd2, 1'b0, 32'hCAFE0000);
    set_ldr(1'b1, 1'b1, 8'h00, $urandom);
    check_cycle(cg, lg);
    chk("release_c_gnt", 32'(bus.C_GNT), 32'd1);
    chk("release_l_gnt", 32'(bus.L_GNT), 32'd0);
    next_cycle();
    set_core(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 32'h0);
    for (int w = 0; w < 64; w++) begin
      set_ldr(1'b1, 1'b1, 8'(w * 4 + (w % 4)), $urandom);
      check_cycle(cg, lg);
      next_cycle();
    end
    set_ldr(1'b0, 1'b0, 8'h00, 32'h0);

    // Directed store/load table
    for (int i = 0; i < 13; i++) begin
      set_core(1'b1, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata);
      check_cycle(cg, lg);
      chk($sformatf("tbl%0d_gnt", i), 32'(bus.C_GNT), 32'd1);
      chk($sformatf("tbl%0d_we", i), 32'(bus.M_WE), 32'(tbl[i].x_we));
      chk($sformatf("tbl%0d_re", i), 32'(bus.M_RE), 32'(tbl[i].x_re));
      chk($sformatf("tbl%0d_din", i), bus.M_DIN, tbl[i].x_din);
      chk($sformatf("tbl%0d_maddr", i), 32'(bus.M_ADDR),
          (tbl[i].x_we == 4'b0000 && !tbl[i].x_re) ? 32'd0 : 32'd4);
      if (i > 0) begin
        chk($sformatf("tbl%0d_rv", i - 1), 32'(bus.C_RVALID), 32'(tbl[i-1].x_rv));
        chk($sformatf("tbl%0d_rd", i - 1), bus.C_RDATA, tbl[i-1].x_rd);
        chk($sformatf("tbl%0d_err", i - 1), 32'(bus.C_ERR), 32'(tbl[i-1].x_err));
      end
      next_cycle();
    end
    set_core(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 32'h0);
    check_cycle(cg, lg);
    chk("tbl12_rv", 32'(bus.C_RVALID), 32'(tbl[12].x_rv));
    chk("tbl12_rd", bus.C_RDATA, tbl[12].x_rd);
    next_cycle();

    // Contention: loader granted first so the alternation starts with the core
    set_ldr(1'b1, 1'b0, 8'h40, 32'h0);
    check_cycle(cg, lg);
    next_cycle();
    for (int k = 0; k < 7; k++) begin
      if (k < 6) begin
        set_core(1'b1, 1'b0, 8'($urandom_range(0, 255)), 2'd2, 1'b0, 32'h0);
        set_ldr(1'b1, 1'b0, 8'($urandom_range(0, 255)), 32'h0);
      end else begin
        set_core(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 32'h0);
        set_ldr(1'b0, 1'b0, 8'h00, 32'h0);
      end
      check_cycle(cg, lg);
      if (k < 6) begin
        chk($sformatf("rr%0d_c_gnt", k), 32'(bus.C_GNT), 32'(k % 2 == 0));
        chk($sformatf("rr%0d_l_gnt", k), 32'(bus.L_GNT), 32'(k % 2 == 1));
      end
      chk($sformatf("rr%0d_c_rv", k), 32'(bus.C_RVALID), 32'(k > 0 && (k % 2 == 1)));
      chk($sformatf("rr%0d_l_rv", k), 32'(bus.L_RVALID), 32'(k == 0 || (k % 2 == 0)));
      next_cycle();
    end

    // Reset arriving the cycle after a granted read kills the response
    set_core(1'b1, 1'b0, 8'h20, 2'd2, 1'b0, 32'h0);
    check_cycle(cg, lg);
    chk("midrst_gnt", 32'(bus.C_GNT), 32'd1);
    next_cycle();
    rst = 1'b1;
    set_ldr(1'b1, 1'b0, 8'h24, 32'h0);
    check_cycle(cg, lg);
    chk("midrst_n1_rv", 32'(bus.C_RVALID), 32'd0);
    next_cycle();
    rst = 1'b0;
    set_core(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 32'h0);
    set_ldr(1'b0, 1'b0, 8'h00, 32'h0);
    check_cycle(cg, lg);
    chk("midrst_n2_rv", 32'(bus.C_RVALID), 32'd0);
    next_cycle();

    // Randomized traffic; a requester that lost keeps its request unchanged
    c_hold = 1'b0; l_hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!c_hold)
        set_core($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)),
                 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom);
      if (!l_hold)
        set_ldr($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)), $urandom);
      check_cycle(cg, lg);
      c_hold = bus.C_REQ && !cg && !rst;
      l_hold = bus.L_REQ && !lg && !rst;
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
